// File: rtl/debug_host_link.sv
// Host-side debug link: sends one command byte over the UART tx queue, then
// assembles the returned datapath snapshot and flags completion or an inter-byte timeout.
module debug_host_link #(
  parameter int         SNAP_BYTES     = 172,
  parameter int         CNT_W          = 8,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0] CMD_CONT       = 8'h02
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_start,
  input  logic                    cmd_step,
  input  logic                    tx_full,
  output logic                    tx_write,
  output logic [7:0]              tx_bus,
  input  logic                    rx_rdy,
  input  logic [7:0]              rx_bus,
  output logic [SNAP_BYTES*8-1:0] snapshot,
  output logic                    snapshot_valid,
  output logic                    timeout_err,
  output logic                    busy,
  output logic [CNT_W-1:0]        byte_count
);

  localparam int               TMO_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(SNAP_BYTES - 1);
  localparam logic [7:0]       CMD_STEP  = 8'h01;

  typedef enum logic [2:0] {IDLE, SEND_CMD, RECV, DONE, ABORT} state_t;

  state_t           state_q, state_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [CNT_W-1:0] count_d;
  logic [7:0]       tx_bus_d;
  logic             tx_write_d, valid_d, terr_d, store_en;

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    tmo_d      = tmo_q;
    count_d    = byte_count;
    tx_bus_d   = tx_bus;
    tx_write_d = 1'b0;
    valid_d    = 1'b0;
    terr_d     = 1'b0;
    store_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_start) begin
          cmd_d   = cmd_step ? CMD_STEP : CMD_CONT;
          count_d = '0;
          tmo_d   = '0;
          state_d = SEND_CMD;
        end
      end
      SEND_CMD: begin
        if (!tx_full) begin
          tx_write_d = 1'b1;
          tx_bus_d   = cmd_q;
          tmo_d      = '0;
          state_d    = RECV;
        end
      end
      RECV: begin
        // A byte arriving on the limit cycle takes priority over the timeout.
        if (rx_rdy) begin
          store_en = 1'b1;
          count_d  = byte_count + 1'b1;
          tmo_d    = '0;
          if (byte_count == LAST_IDX) begin
            valid_d = 1'b1;
            state_d = DONE;
          end
        end else if (TIMEOUT_CYCLES != 0) begin
          tmo_d = tmo_q + 1'b1;
          if (tmo_d == TMO_LIMIT) begin
            terr_d  = 1'b1;
            state_d = ABORT;
          end
        end
      end
      DONE:    state_d = IDLE;
      ABORT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      cmd_q          <= '0;
      tmo_q          <= '0;
      byte_count     <= '0;
      tx_write       <= 1'b0;
      tx_bus         <= '0;
      snapshot_valid <= 1'b0;
      timeout_err    <= 1'b0;
      busy           <= 1'b0;
      snapshot       <= '0;
    end else begin
      state_q        <= state_d;
      cmd_q          <= cmd_d;
      tmo_q          <= tmo_d;
      byte_count     <= count_d;
      tx_write       <= tx_write_d;
      tx_bus         <= tx_bus_d;
      snapshot_valid <= valid_d;
      timeout_err    <= terr_d;
      busy           <= (state_d != IDLE);
      if (store_en) snapshot[{byte_count, 3'b000} +: 8] <= rx_bus;
    end
  end

endmodule

// File: tb/tb_debug_host_link.sv
// Directed bench for debug_host_link: step, backpressure, timeout, timeout race,
// ignore rules and mid-transfer reset, checked with immediate assertions.
module tb_debug_host_link;
  localparam int SNAP_BYTES = 172;
  localparam int CNT_W      = 8;
  localparam int TMO        = 50;
  localparam int SW         = SNAP_BYTES * 8;

  logic             clk = 1'b0;
  logic             reset, cmd_start, cmd_step, tx_full, rx_rdy;
  logic [7:0]       rx_bus;
  logic             tx_write, snapshot_valid, timeout_err, busy;
  logic [7:0]       tx_bus;
  logic [SW-1:0]    snapshot;
  logic [CNT_W-1:0] byte_count;

  int n_cmp = 0, n_err = 0;
  int n_txw = 0, n_sv = 0, n_te = 0;
  int t0, sv0, te0;
  logic [SW-1:0] exp_snap;
  logic [7:0]    v;

  debug_host_link #(
    .SNAP_BYTES(SNAP_BYTES), .CNT_W(CNT_W), .TIMEOUT_CYCLES(TMO), .CMD_CONT(8'h02)
  ) dut (
    .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_step(cmd_step),
    .tx_full(tx_full), .tx_write(tx_write), .tx_bus(tx_bus),
    .rx_rdy(rx_rdy), .rx_bus(rx_bus), .snapshot(snapshot),
    .snapshot_valid(snapshot_valid), .timeout_err(timeout_err),
    .busy(busy), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_write) n_txw++;
    if (snapshot_valid) n_sv++;
    if (timeout_err) n_te++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_cmp++;
    assert (obs === req) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, req);
    end
  endtask

  task automatic check_snap(input string tag, input logic [SW-1:0] req);
    int first;
    first = -1;
    n_cmp++;
    assert (snapshot === req) else begin
      n_err++;
      for (int b = SNAP_BYTES - 1; b >= 0; b--)
        if (snapshot[8*b +: 8] !== req[8*b +: 8]) first = b;
      $error("FAIL %s: byte %0d observed 0x%0h expected 0x%0h", tag, first,
             snapshot[8*first +: 8], req[8*first +: 8]);
    end
  endtask

  task automatic start_cmd(input logic step);
    cmd_start = 1'b1;
    cmd_step  = step;
    tick();
    cmd_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_rdy = 1'b1;
    rx_bus = b;
    tick();
    rx_rdy = 1'b0;
    repeat (gap) tick();
  endtask

  initial begin
    reset = 1'b1; cmd_start = 1'b0; cmd_step = 1'b0; tx_full = 1'b0;
    rx_rdy = 1'b0; rx_bus = 8'h00;
    exp_snap = '0;
    #3;
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_tx_write", 32'(tx_write), 32'(0));
    check("rst_tx_bus", 32'(tx_bus), 32'(0));
    check("rst_count", 32'(byte_count), 32'(0));
    check("rst_valid", 32'(snapshot_valid), 32'(0));
    check("rst_terr", 32'(timeout_err), 32'(0));
    check_snap("rst_snap", exp_snap);
    tick(); tick();
    reset = 1'b0;
    tick();

    // Single step, no backpressure
    t0 = n_txw; sv0 = n_sv;
    start_cmd(1'b1);
    check("step_busy", 32'(busy), 32'(1));
    check("step_tx_early", 32'(tx_write), 32'(0));
    tick();
    check("step_tx_write", 32'(tx_write), 32'(1));
    check("step_tx_bus", 32'(tx_bus), 32'(8'h01));
    tick();
    check("step_tx_once", 32'(tx_write), 32'(0));
    for (int i = 0; i < SNAP_BYTES; i++) begin
      exp_snap[8*i +: 8] = 8'(i);
      send_byte(8'(i), (i == SNAP_BYTES - 1) ? 0 : 3);
    end
    check("step_valid", 32'(snapshot_valid), 32'(1));
    check("step_count", 32'(byte_count), 32'(172));
    tick();
    check("step_valid_off", 32'(snapshot_valid), 32'(0));
    check("step_idle", 32'(busy), 32'(0));
    check("step_byte0", 32'(snapshot[7:0]), 32'(8'h00));
    check("step_byte171", 32'(snapshot[SW-1 -: 8]), 32'(8'hAB));
    check_snap("step_snap", exp_snap);
    check("step_valid_pulses", 32'(n_sv - sv0), 32'(1));
    check("step_tx_pulses", 32'(n_txw - t0), 32'(1));

    // Stray bytes in IDLE
    repeat (3) send_byte(8'hEE, 1);
    check_snap("idle_stray_snap", exp_snap);
    check("idle_stray_count", 32'(byte_count), 32'(172));
    check("idle_stray_busy", 32'(busy), 32'(0));

    // Continuous command under backpressure, then timeout after 10 bytes
    tx_full = 1'b1;
    t0 = n_txw; sv0 = n_sv; te0 = n_te;
    start_cmd(1'b0);
    for (int k = 0; k < 10; k++) begin
      check("bp_hold", 32'({busy, tx_write}), 32'(2'b10));
      tick();
    end
    tx_full = 1'b0;
    tick();
    check("bp_tx_write", 32'(tx_write), 32'(1));
    check("bp_tx_bus", 32'(tx_bus), 32'(8'h02));
    check("bp_busy", 32'(busy), 32'(1));
    tick();
    check("bp_tx_once", 32'(tx_write), 32'(0));
    check("bp_tx_pulses", 32'(n_txw - t0), 32'(1));
    for (int i = 0; i < 10; i++) begin
      exp_snap[8*i +: 8] = 8'hC0 + 8'(i);
      send_byte(8'hC0 + 8'(i), (i == 9) ? 0 : 3);
    end
    repeat (TMO - 1) tick();
    check("tmo_early", 32'(timeout_err), 32'(0));
    tick();
    check("tmo_pulse", 32'(timeout_err), 32'(1));
    check("tmo_count", 32'(byte_count), 32'(10));
    check("tmo_busy_abort", 32'(busy), 32'(1));
    tick();
    check("tmo_pulse_off", 32'(timeout_err), 32'(0));
    check("tmo_busy_drop", 32'(busy), 32'(0));
    check("tmo_pulses", 32'(n_te - te0), 32'(1));
    check("tmo_no_valid", 32'(n_sv - sv0), 32'(0));
    check_snap("tmo_partial_snap", exp_snap);

    // Byte arriving on the limit cycle, plus cmd_start mid-RECV
    t0 = n_txw; sv0 = n_sv; te0 = n_te;
    start_cmd(1'b1);
    tick();
    check("race_tx_write", 32'(tx_write), 32'(1));
    tick();
    for (int i = 0; i < SNAP_BYTES; i++) begin
      v = 8'(i * 7 + 3);
      exp_snap[8*i +: 8] = v;
      rx_rdy = 1'b1;
      rx_bus = v;
      tick();
      rx_rdy = 1'b0;
      if (i == 5) begin
        check("race_no_terr", 32'(timeout_err), 32'(0));
        check("race_busy", 32'(busy), 32'(1));
        check("race_count", 32'(byte_count), 32'(6));
      end
      if (i == 20) begin
        cmd_start = 1'b1;
        cmd_step  = 1'b0;
      end
      if (i != SNAP_BYTES - 1)
        repeat ((i == 4) ? TMO - 1 : 3) begin
          tick();
          cmd_start = 1'b0;
        end
    end
    check("race_valid", 32'(snapshot_valid), 32'(1));
    check("race_full_count", 32'(byte_count), 32'(172));
    tick();
    check("race_idle", 32'(busy), 32'(0));
    check_snap("race_snap", exp_snap);
    check("race_tx_pulses", 32'(n_txw - t0), 32'(1));
    check("race_terr_pulses", 32'(n_te - te0), 32'(0));
    check("race_valid_pulses", 32'(n_sv - sv0), 32'(1));

    // Reset after byte 80, then a full capture
    sv0 = n_sv; te0 = n_te;
    start_cmd(1'b1);
    tick(); tick();
    for (int i = 0; i <= 80; i++) send_byte(8'(i) ^ 8'h5A, (i == 80) ? 0 : 3);
    check("mid_count", 32'(byte_count), 32'(81));
    #2;
    reset = 1'b1;
    #1;
    exp_snap = '0;
    check("mrst_busy", 32'(busy), 32'(0));
    check("mrst_tx_write", 32'(tx_write), 32'(0));
    check("mrst_tx_bus", 32'(tx_bus), 32'(0));
    check("mrst_valid", 32'(snapshot_valid), 32'(0));
    check("mrst_terr", 32'(timeout_err), 32'(0));
    check("mrst_count", 32'(byte_count), 32'(0));
    check_snap("mrst_snap", exp_snap);
    tick();
    reset = 1'b0;
    tick();
    check("mrst_idle", 32'(busy), 32'(0));
    send_byte(8'h77, 1);
    check_snap("mrst_stray_snap", exp_snap);
    check("mrst_no_valid", 32'(n_sv - sv0), 32'(0));
    check("mrst_no_terr", 32'(n_te - te0), 32'(0));
    start_cmd(1'b1);
    tick();
    check("post_tx_write", 32'(tx_write), 32'(1));
    check("post_tx_bus", 32'(tx_bus), 32'(8'h01));
    tick();
    for (int i = 0; i < SNAP_BYTES; i++) begin
      exp_snap[8*i +: 8] = 8'(i) ^ 8'hA5;
      send_byte(8'(i) ^ 8'hA5, (i == SNAP_BYTES - 1) ? 0 : 2);
    end
    check("post_valid", 32'(snapshot_valid), 32'(1));
    check("post_count", 32'(byte_count), 32'(172));
    tick();
    check("post_idle", 32'(busy), 32'(0));
    check_snap("post_snap", exp_snap);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/debug_host_link.md
Name: debug_host_link

Overview:
- Host-side counterpart of the MIPS debug unit.
- Issues one debug command byte: 0x01 runs a single step; any other value runs until halt. The command goes over the UART byte interface.
- Collects the returned datapath snapshot byte-by-byte into a wide register and flags completion or an inter-byte timeout.
- Sits between a UART core (tx queue and rx byte strobe) and a monitor or loopback harness driving cmd_start.

Parameters:
- SNAP_BYTES, 172, number of snapshot bytes per command (1376 bits).
- CNT_W, 8, width of the byte counter; must satisfy 2^CNT_W > SNAP_BYTES.
- TIMEOUT_CYCLES, 1000000, maximum clk cycles allowed between received bytes in RECV; 0 disables the timeout.
- CMD_CONT, 8'h02, byte sent for a continuous-run command.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_start  in  1  one-cycle request to start a command; sampled only in IDLE.
- cmd_step  in  1  sampled with cmd_start: 1 = single step (send 0x01), 0 = continuous (send CMD_CONT).
- tx_full  in  1  UART tx queue full; a write is not issued while high.
- tx_write  out  1  one-cycle write strobe to the UART tx queue.
- tx_bus  out  8  command byte; valid when tx_write=1.
- rx_rdy  in  1  one-cycle strobe: rx_bus holds a new byte.
- rx_bus  in  8  received byte.
- snapshot  out  SNAP_BYTES*8  assembled snapshot; held stable outside RECV.
- snapshot_valid  out  1  one-cycle pulse when the last byte has been stored.
- timeout_err  out  1  one-cycle pulse on timeout abort.
- busy  out  1  high in every state except IDLE.
- byte_count  out  CNT_W  number of bytes stored in the current transfer.

Behaviour:
- Reset (asynchronous) values:
  - State = IDLE.
  - tx_write, tx_bus, snapshot_valid, timeout_err, busy, byte_count = 0.
  - snapshot = 0.
  - Timeout counter = 0.
- FSM states: IDLE, SEND_CMD, RECV, DONE, ABORT.
- IDLE:
  - On cmd_start=1, latch the command byte (0x01 if cmd_step=1, else CMD_CONT).
  - Clear byte_count and the timeout counter; go to SEND_CMD next cycle.
  - rx_rdy pulses in IDLE are ignored; stray bytes are dropped.
- SEND_CMD:
  - If tx_full=0, assert tx_write=1 with tx_bus=command for exactly one cycle, then go to RECV.
  - If tx_full=1, wait in SEND_CMD with tx_write=0.
  - Latency from cmd_start to tx_write is 2 cycles when the queue is not full.
- RECV:
  - On each rx_rdy=1, store rx_bus into snapshot[8*byte_count +: 8], increment byte_count, and clear the timeout counter. The first received byte lands in bits [7:0].
  - If the stored byte is byte index SNAP_BYTES-1, go to DONE.
  - Otherwise, if TIMEOUT_CYCLES≠0, increment the timeout counter every cycle without rx_rdy. When it reaches TIMEOUT_CYCLES, go to ABORT.
  - If rx_rdy arrives in the same cycle the counter reaches its limit, the byte wins: it is stored and the counter cleared.
  - In continuous mode the first byte arrives only after the target halts, so the timeout also covers the run time. Size TIMEOUT_CYCLES accordingly or set it to 0.
- DONE: snapshot_valid=1 for one cycle; go to IDLE. byte_count holds SNAP_BYTES until the next cmd_start.
- ABORT:
  - timeout_err=1 for one cycle; go to IDLE.
  - snapshot keeps the partial contents; byte_count keeps the partial count.
- cmd_start while busy=1 is ignored; no queuing.
- Reset mid-transfer aborts immediately with no pulse on snapshot_valid or timeout_err. Bytes received after reset are treated as stray in IDLE.
- Bytes beyond SNAP_BYTES cannot be stored: the FSM has already left RECV.
- All outputs are registered.

Test Plan:
- Step command: cmd_step=1 with tx_full=0.
  - tx_write pulses once, 2 cycles after cmd_start, with tx_bus=0x01.
  - Then feed 172 bytes, value = index mod 256, spaced by 3 idle cycles.
  - snapshot_valid pulses once; snapshot[7:0]=0x00 and snapshot[1375:1368]=0xAB; byte_count=172.
- Continuous command under backpressure: cmd_step=0 with tx_full=1 for 10 cycles.
  - No tx_write while tx_full=1.
  - After release, exactly one tx_write with tx_bus=0x02; busy stays high throughout.
- Timeout: TIMEOUT_CYCLES=50; send 10 bytes, then stop.
  - timeout_err pulses 50 cycles after the 10th rx_rdy; no snapshot_valid.
  - byte_count=10; busy drops the following cycle.
- Boundary race: rx_rdy in the exact cycle the timeout counter reaches 50.
  - Byte stored, no timeout_err; the transfer completes normally.
- Ignore rules: rx_rdy pulses in IDLE and cmd_start asserted mid-RECV.
  - Both ignored; snapshot unchanged, a single tx_write per transfer.
- Reset mid-operation: assert reset after byte 80.
  - All outputs zero asynchronously, state IDLE, no pulses.
  - A new step command then completes a full 172-byte capture.
